// File: rtl/ysyx_25020042_pkg.sv
// rtl/ysyx_25020042_pkg.sv - shared size and FSM encodings for the data memory
package ysyx_25020042_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_WORD3 = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/ysyx_25020042_ld_ext.sv
// rtl/ysyx_25020042_ld_ext.sv - load lane extraction and sign/zero extension
module ysyx_25020042_ld_ext
  import ysyx_25020042_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word_i,
  input  logic [1:0]       off_i,
  input  size_e            size_i,
  input  logic             unsigned_i,
  output logic [WIDTH-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[8*off_i +: 8];
    half_sel = word_i[16*off_i[1] +: 16];
    data_o   = word_i;
    case (size_i)
      SZ_BYTE: data_o = unsigned_i ? {{(WIDTH-8){1'b0}}, byte_sel}
                                   : {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      SZ_HALF: data_o = unsigned_i ? {{(WIDTH-16){1'b0}}, half_sel}
                                   : {{(WIDTH-16){half_sel[15]}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/ysyx_25020042_dmem.sv
// rtl/ysyx_25020042_dmem.sv - single-outstanding data memory with configurable latency
// Define YSYX_25020042_DMEM_MISALIGN_CHK_EN to fault misaligned half/word accesses.
module ysyx_25020042_dmem
  import ysyx_25020042_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_addr,
  input  logic             req_wen,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] addr_q, wdata_q;
  logic             wen_q, uns_q;
  size_e            size_q;
  logic [WIDTH-1:0] rsp_rdata_q;
  logic             rsp_err_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             hs, fire, misal;
  logic [WIDTH-1:0] cur_addr, cur_wdata, rd_word, ld_data, st_data;
  logic             cur_wen, cur_uns;
  size_e            cur_size;
  logic [AW-1:0]    cur_idx;
  logic [NB-1:0]    be;
  logic             unused_addr;

  assign req_ready = (state_q == ST_IDLE);
  assign hs        = req_valid && req_ready;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // With LATENCY=1 the access fires on the handshake edge, before the latches are loaded.
  assign cur_addr  = req_ready ? req_addr : addr_q;
  assign cur_wdata = req_ready ? req_wdata : wdata_q;
  assign cur_wen   = req_ready ? req_wen : wen_q;
  assign cur_uns   = req_ready ? req_unsigned : uns_q;
  assign cur_size  = req_ready ? size_e'(req_size) : size_q;
  assign cur_idx   = cur_addr[AW+1:2];
  assign rd_word   = mem_q[cur_idx];
  assign unused_addr = ^cur_addr[WIDTH-1:AW+2];

`ifdef YSYX_25020042_DMEM_MISALIGN_CHK_EN
  assign misal = ((cur_size == SZ_HALF) && cur_addr[0]) ||
                 (((cur_size == SZ_WORD) || (cur_size == SZ_WORD3)) && (cur_addr[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          if (LATENCY == 1) begin
            state_d = ST_RESP;
            fire    = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
          cnt_d   = 4'd0;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    be      = '1;
    st_data = cur_wdata;
    case (cur_size)
      SZ_BYTE: begin
        be      = NB'(1) << cur_addr[1:0];
        st_data = {NB{cur_wdata[7:0]}};
      end
      SZ_HALF: begin
        be      = cur_addr[1] ? NB'(4'b1100) : NB'(4'b0011);
        st_data = {(NB/2){cur_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  ysyx_25020042_ld_ext #(.WIDTH(WIDTH)) u_ld_ext (
    .word_i     (rd_word),
    .off_i      (cur_addr[1:0]),
    .size_i     (cur_size),
    .unsigned_i (cur_uns),
    .data_o     (ld_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fire) begin
        rsp_err_q   <= misal;
        rsp_rdata_q <= (cur_wen || misal) ? '0 : ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hs) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wen_q   <= req_wen;
      uns_q   <= req_unsigned;
      size_q  <= size_e'(req_size);
    end
  end

  // Memory is not reset; a store is only dropped if reset lands before it fires.
  always_ff @(posedge clk) begin
    if (rst_n && fire && cur_wen && !misal) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem_q[cur_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25020042_dmem.sv
// tb/tb_ysyx_25020042_dmem.sv - directed bench for two dmem instances (LATENCY 1 and 4)
module tb_ysyx_25020042_dmem;

  logic        clk;
  logic        rst_n;
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic [31:0] req_addr     [2];
  logic        req_wen      [2];
  logic [31:0] req_wdata    [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic        rsp_valid    [2];
  logic        rsp_ready    [2];
  logic [31:0] rsp_rdata    [2];
  logic        rsp_err      [2];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ysyx_25020042_dmem #(.WIDTH(32), .DEPTH(1024), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_wen(req_wen[0]), .req_wdata(req_wdata[0]), .req_size(req_size[0]),
    .req_unsigned(req_unsigned[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  ysyx_25020042_dmem #(.WIDTH(32), .DEPTH(1024), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_wen(req_wen[1]), .req_wdata(req_wdata[1]), .req_size(req_size[1]),
    .req_unsigned(req_unsigned[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic issue(input int d, input logic [31:0] a, input logic wen, input logic [31:0] wd,
                       input logic [1:0] sz, input logic uns,
                       output int lat, output logic [31:0] rd, output logic er);
    int n;
    n = 0;
    req_valid[d] = 1'b1; req_addr[d] = a; req_wen[d] = wen;
    req_wdata[d] = wd; req_size[d] = sz; req_unsigned[d] = uns;
    while (req_ready[d] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 1;
    while (rsp_valid[d] !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = rsp_rdata[d];
    er = rsp_err[d];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_addr[d] = '0; req_wen[d] = 1'b0; req_wdata[d] = '0;
      req_size[d] = 2'b10; req_unsigned[d] = 1'b0; rsp_ready[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 || rsp_err[d] !== 1'b0) begin
        bad++;
        $display("FAIL reset_out[%0d] valid=%b rdata=%h err=%b exp 0/0/0", d, rsp_valid[d], rsp_rdata[d], rsp_err[d]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (req_ready[d] !== 1'b1) begin bad++; $display("FAIL reset_ready[%0d] got=%b exp=1", d, req_ready[d]); end
    end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic er;
    issue(0, 32'h10, 1'b1, 32'hDEADBEEF, 2'b10, 1'b0, lat, rd, er);
    total++;
    if (lat !== 1 || rd !== 32'h0 || er !== 1'b0) begin
      bad++; $display("FAIL st_word lat=%0d rd=%h er=%b exp 1/0/0", lat, rd, er);
    end
    issue(0, 32'h10, 1'b0, 32'h0, 2'b10, 1'b0, lat, rd, er);
    total++;
    if (lat !== 1 || rd !== 32'hDEADBEEF) begin
      bad++; $display("FAIL ld_word lat=%0d rd=%h exp 1/deadbeef", lat, rd);
    end
  endtask

  task automatic test_load_ext();
    int lat; logic [31:0] rd; logic er;
    logic [31:0] addr_v [6] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10, 32'h10};
    logic [1:0]  size_v [6] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01};
    logic        uns_v  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_v  [6] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD,
                                32'h000000EF, 32'h0000BEEF, 32'hFFFFBEEF};
    for (int i = 0; i < 6; i++) begin
      issue(0, addr_v[i], 1'b0, 32'h0, size_v[i], uns_v[i], lat, rd, er);
      total++;
      if (rd !== exp_v[i] || er !== 1'b0) begin
        bad++; $display("FAIL ld_ext[%0d] rd=%h er=%b exp %h/0", i, rd, er, exp_v[i]);
      end
    end
  endtask

  task automatic test_misalign();
    int lat; logic [31:0] rd; logic er;
    logic [31:0] exp_rd; logic exp_er;
`ifdef YSYX_25020042_DMEM_MISALIGN_CHK_EN
    exp_rd = 32'h0; exp_er = 1'b1;
`else
    exp_rd = 32'hDEADBEEF; exp_er = 1'b0;
`endif
    issue(0, 32'h11, 1'b0, 32'h0, 2'b10, 1'b0, lat, rd, er);
    total++;
    if (lat !== 1 || rd !== exp_rd || er !== exp_er) begin
      bad++; $display("FAIL misalign lat=%0d rd=%h er=%b exp 1/%h/%b", lat, rd, er, exp_rd, exp_er);
    end
    issue(0, 32'h10, 1'b0, 32'h0, 2'b10, 1'b0, lat, rd, er);
    total++;
    if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL misalign_mem rd=%h exp=deadbeef", rd); end
  endtask

  task automatic test_store_lanes();
    int lat; logic [31:0] rd; logic er;
    issue(0, 32'h11, 1'b1, 32'hAAAAAA55, 2'b00, 1'b0, lat, rd, er);
    issue(0, 32'h10, 1'b0, 32'h0, 2'b10, 1'b0, lat, rd, er);
    total++;
    if (rd !== 32'hDEAD55EF) begin bad++; $display("FAIL st_byte rd=%h exp=dead55ef", rd); end
    issue(0, 32'h14, 1'b1, 32'h0, 2'b10, 1'b0, lat, rd, er);
    issue(0, 32'h16, 1'b1, 32'hFFFF1234, 2'b01, 1'b0, lat, rd, er);
    issue(0, 32'h15, 1'b1, 32'h0000009A, 2'b00, 1'b0, lat, rd, er);
    issue(0, 32'h14, 1'b0, 32'h0, 2'b11, 1'b0, lat, rd, er);
    total++;
    if (rd !== 32'h12349A00) begin bad++; $display("FAIL st_half_byte rd=%h exp=12349a00", rd); end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] rd; logic er;
    issue(0, 32'h1010, 1'b1, 32'h0BADF00D, 2'b10, 1'b0, lat, rd, er);
    issue(0, 32'h10, 1'b0, 32'h0, 2'b10, 1'b0, lat, rd, er);
    total++;
    if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL wrap rd=%h exp=0badf00d", rd); end
  endtask

  task automatic test_latency();
    int lat; int n; logic [31:0] rd; logic er; logic ok_ready; logic ok_hold;
    issue(1, 32'h40, 1'b1, 32'hCAFEF00D, 2'b10, 1'b0, lat, rd, er);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL lat4_store lat=%0d exp=4", lat); end
    rsp_ready[1] = 1'b0;
    req_valid[1] = 1'b1; req_addr[1] = 32'h40; req_wen[1] = 1'b0; req_size[1] = 2'b10; req_unsigned[1] = 1'b0;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    ok_ready = 1'b1;
    n = 1;
    while (rsp_valid[1] !== 1'b1 && n < 20) begin
      if (req_ready[1] !== 1'b0) ok_ready = 1'b0;
      @(posedge clk); #1; n++;
    end
    total++;
    if (n !== 4 || ok_ready !== 1'b1) begin bad++; $display("FAIL lat4_load cycles=%0d ready_low=%b exp 4/1", n, ok_ready); end
    total++;
    if (rsp_rdata[1] !== 32'hCAFEF00D) begin bad++; $display("FAIL lat4_rdata rd=%h exp=cafef00d", rsp_rdata[1]); end
    ok_hold = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'hCAFEF00D || rsp_err[1] !== 1'b0 || req_ready[1] !== 1'b0)
        ok_hold = 1'b0;
    end
    total++;
    if (ok_hold !== 1'b1) begin bad++; $display("FAIL lat4_hold stable=%b exp=1", ok_hold); end
    rsp_ready[1] = 1'b1;
    total++;
    if (req_ready[1] !== 1'b0) begin bad++; $display("FAIL retire_cycle_ready got=%b exp=0", req_ready[1]); end
    @(posedge clk); #1;
    total++;
    if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
      bad++; $display("FAIL after_retire valid=%b ready=%b exp 0/1", rsp_valid[1], req_ready[1]);
    end
  endtask

  task automatic test_reset_wait();
    int lat; logic [31:0] rd; logic er;
    issue(1, 32'h20, 1'b1, 32'h11111111, 2'b10, 1'b0, lat, rd, er);
    req_valid[1] = 1'b1; req_addr[1] = 32'h20; req_wen[1] = 1'b1; req_wdata[1] = 32'h12345678; req_size[1] = 2'b10;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
      bad++; $display("FAIL rst_wait valid=%b ready=%b exp 0/1", rsp_valid[1], req_ready[1]);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin
      bad++; $display("FAIL rst_release valid=%b ready=%b exp 0/1", rsp_valid[1], req_ready[1]);
    end
    issue(1, 32'h20, 1'b0, 32'h0, 2'b10, 1'b0, lat, rd, er);
    total++;
    if (rd !== 32'h11111111 || lat !== 4) begin
      bad++; $display("FAIL rst_dropped rd=%h lat=%0d exp 11111111/4", rd, lat);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_load_ext();
    test_misalign();
    test_store_lanes();
    test_wrap();
    test_latency();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
